boot_loader_ctrl: RTL and testbench

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_pkg.sv | 18 +
 rtl/boot_byte_fetch.sv | 38 +++
 rtl/boot_loader_ctrl.sv | 156 +++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader.
package boot_pkg;

   typedef enum logic [2:0] {
      StSync,
      StLenLo,
      StLenHi,
      StData,
      StCheck,
      StDone,
      StError
   } boot_state_e;

   localparam logic [7:0] DefaultMagic = 8'hA5;

   typedef logic [15:0] len_t;

endpackage

// File: rtl/boot_byte_fetch.sv
// Byte fetcher: issues single FIFO reads and presents each captured byte as a one-cycle pulse.
module boot_byte_fetch (
   input  logic       clk,
   input  logic       rst,
   input  logic       fetch_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rd_data,
   output logic       fifo_rd_en,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   logic       pending_q;
   logic       valid_q;
   logic [7:0] data_q;

   // Hold off the next read until the captured byte has been consumed, so a byte that moves
   // the FSM into a terminal state is never followed by another read.
   assign fifo_rd_en = !rst && fetch_en && !fifo_empty && !pending_q && !valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= 8'h00;
      end else begin
         pending_q <= fifo_rd_en;
         valid_q   <= pending_q;
         if (pending_q) begin
            data_q <= fifo_rd_data;
         end
      end
   end

   assign byte_valid = valid_q;
   assign byte_data  = data_q;

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: parses a MAGIC/length/data/checksum packet from a byte FIFO into instruction memory.
module boot_loader_ctrl
   import boot_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [7:0]  MAGIC      = DefaultMagic
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [7:0]            fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  boot_done,
   output logic                  boot_err
);

   localparam int unsigned MaxWords = 1 << ADDR_WIDTH;

   boot_state_e           state_q, state_d;
   len_t                  len_q, len_d;
   len_t                  word_cnt_q, word_cnt_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [23:0]           word_buf_q, word_buf_d;
   logic [7:0]            csum_q, csum_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  hold_q, done_q, err_q;

   logic       fetch_en;
   logic       byte_valid;
   logic [7:0] byte_data;
   len_t       new_len;

   assign fetch_en = (state_q != StDone) && (state_q != StError);
   assign new_len  = {byte_data, len_q[7:0]};

   boot_byte_fetch u_byte_fetch (
      .clk          (clk),
      .rst          (rst),
      .fetch_en     (fetch_en),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      word_buf_d = word_buf_q;
      csum_d     = csum_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;

      // Address advances the cycle after each write strobe, wrapping naturally at 2**ADDR_WIDTH.
      if (we_q) begin
         addr_d = addr_q + ADDR_WIDTH'(1);
      end

      if (byte_valid) begin
         case (state_q)
            StSync: begin
               if (byte_data == MAGIC) begin
                  state_d    = StLenLo;
                  csum_d     = 8'h00;
                  addr_d     = '0;
                  word_cnt_d = '0;
                  byte_idx_d = 2'd0;
               end
            end
            StLenLo: begin
               len_d[7:0] = byte_data;
               state_d    = StLenHi;
            end
            StLenHi: begin
               len_d[15:8] = byte_data;
               if (new_len == '0) begin
                  state_d = StCheck;
               end else if (32'(new_len) > MaxWords) begin
                  state_d = StError;
               end else begin
                  state_d = StData;
               end
            end
            StData: begin
               csum_d     = csum_q + byte_data;
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: word_buf_d[7:0]   = byte_data;
                  2'd1: word_buf_d[15:8]  = byte_data;
                  2'd2: word_buf_d[23:16] = byte_data;
                  default: begin
                     wdata_d    = {byte_data, word_buf_q};
                     we_d       = 1'b1;
                     word_cnt_d = word_cnt_q + 16'd1;
                     if (word_cnt_q + 16'd1 == len_q) begin
                        state_d = StCheck;
                     end
                  end
               endcase
            end
            StCheck: begin
               state_d = (byte_data == csum_q) ? StDone : StError;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StSync;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_idx_q <= 2'd0;
         word_buf_q <= 24'h0;
         csum_q     <= 8'h00;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         we_q       <= 1'b0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         word_buf_q <= word_buf_d;
         csum_q     <= csum_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         hold_q     <= (state_d != StDone);
         done_q     <= (state_d == StDone);
         err_q      <= (state_d == StError);
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign boot_done  = done_q;
   assign boot_err   = err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: FIFO model, packet reference model and write monitor.
module tb_boot_loader_ctrl;

   localparam int unsigned AW = 10;
   localparam logic [7:0]  MG = 8'hA5;

   typedef enum int {OutNone, OutDone, OutErr} out_e;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_empty;
   logic [7:0]    fifo_rd_data;
   logic          fifo_rd_en;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold;
   logic          boot_done;
   logic          boot_err;

   int            errors = 0;
   int            checks = 0;
   bit            stall_en = 1'b0;
   logic          prev_rd = 1'b0;
   byte unsigned  fifo_q[$];
   logic [AW-1:0] exp_addr_q[$];
   logic [31:0]   exp_data_q[$];

   always #5 clk = ~clk;

   boot_loader_ctrl #(
      .ADDR_WIDTH (AW),
      .MAGIC      (MG)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .boot_done    (boot_done),
      .boot_err     (boot_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Packet parser from the packet format: expected writes go to the scoreboard queues.
   task automatic model(input byte unsigned s[$], output out_e res);
      int           i;
      int           n;
      byte unsigned sum;
      logic [31:0]  w;
      res = OutNone;
      i   = 0;
      sum = 8'h00;
      while (i < s.size() && s[i] != MG) i++;
      if (i + 3 > s.size()) return;
      n = int'(s[i+1]) + 256 * int'(s[i+2]);
      i += 3;
      if (n > (1 << AW)) begin
         res = OutErr;
         return;
      end
      for (int k = 0; k < n; k++) begin
         if (i + 4 > s.size()) return;
         w   = {s[i+3], s[i+2], s[i+1], s[i]};
         sum = 8'(int'(sum) + s[i] + s[i+1] + s[i+2] + s[i+3]);
         exp_addr_q.push_back(AW'(k % (1 << AW)));
         exp_data_q.push_back(w);
         i += 4;
      end
      if (i >= s.size()) return;
      res = (s[i] == sum) ? OutDone : OutErr;
   endtask

   // FIFO model: empty changes just after the rising edge; a read seen mid-cycle pops the byte.
   initial begin
      fifo_empty   = 1'b1;
      fifo_rd_data = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         fifo_empty = (fifo_q.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
         @(negedge clk);
         if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      end
   end

   // Monitor: read protocol and write scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (fifo_rd_en) begin
            check("read_when_empty", {31'b0, fifo_empty}, 32'd0);
            check("two_reads_in_flight", {31'b0, prev_rd}, 32'd0);
         end
         prev_rd = fifo_rd_en;
         if (imem_we) begin
            if (exp_addr_q.size() == 0) begin
               check("unexpected_write_addr", {{(32-AW){1'b0}}, imem_addr}, 32'hFFFF_FFFF);
            end else begin
               check("wr_addr", {{(32-AW){1'b0}}, imem_addr}, {{(32-AW){1'b0}}, exp_addr_q.pop_front()});
               check("wr_data", imem_wdata, exp_data_q.pop_front());
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      stall_en = 1'b0;
      fifo_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      check("rst_we", {31'b0, imem_we}, 32'd0);
      check("rst_addr", {{(32-AW){1'b0}}, imem_addr}, 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_hold", {31'b0, cpu_hold}, 32'd1);
      check("rst_done", {31'b0, boot_done}, 32'd0);
      check("rst_err", {31'b0, boot_err}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_stream(input string name, input byte unsigned s[$], input bit stall);
      out_e res;
      int   cyc;
      do_reset();
      model(s, res);
      stall_en = stall;
      foreach (s[k]) fifo_q.push_back(s[k]);
      cyc = 0;
      @(negedge clk);
      while (!(boot_done || boot_err) && cyc < 30000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 30000) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no completion, expected done or err", name);
      end
      repeat (4) @(negedge clk);
      check({name, "_done"}, {31'b0, boot_done}, {31'b0, res == OutDone});
      check({name, "_err"}, {31'b0, boot_err}, {31'b0, res == OutErr});
      check({name, "_hold"}, {31'b0, cpu_hold}, {31'b0, res != OutDone});
      check({name, "_writes_left"}, exp_addr_q.size(), 32'd0);
      // Terminal states must not read further bytes.
      fifo_q.push_back(8'h5A);
      repeat (6) @(negedge clk);
      check({name, "_no_read_after_end"}, fifo_q.size(), 32'd1);
      exp_addr_q.delete();
      exp_data_q.delete();
   endtask

   initial begin
      byte unsigned pkt[$];
      byte unsigned s[$];
      byte unsigned sum;
      byte unsigned b;
      out_e         res;
      int           cyc;
      int           n;

      rst = 1'b1;
      pkt = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

      run_stream("basic", pkt, 1'b0);

      s = pkt;
      s.push_front(8'hFF);
      s.push_front(8'h00);
      run_stream("junk_prefix", s, 1'b0);

      s = pkt;
      s[s.size()-1] = 8'hB7;
      run_stream("bad_csum", s, 1'b0);

      s = {8'hA5, 8'h00, 8'h00, 8'h00};
      run_stream("zero_len", s, 1'b0);

      s = {8'hA5, 8'h01, 8'h04};
      run_stream("too_long", s, 1'b0);

      run_stream("stalled", pkt, 1'b1);

      // Reset after the sixth data byte, then resend the full packet.
      do_reset();
      s = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
      model(s, res);
      foreach (s[k]) fifo_q.push_back(s[k]);
      cyc = 0;
      while (fifo_q.size() != 0 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (8) @(negedge clk);
      check("midrst_first_write_seen", exp_addr_q.size(), 32'd0);
      check("midrst_not_done", {31'b0, boot_done | boot_err}, 32'd0);
      run_stream("after_midrst", pkt, 1'b0);

      for (int t = 0; t < 6; t++) begin
         s.delete();
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom());
            if (b == MG) b = 8'h00;
            s.push_back(b);
         end
         n = $urandom_range(1, 5);
         s.push_back(MG);
         s.push_back(8'(n));
         s.push_back(8'h00);
         sum = 8'h00;
         repeat (4 * n) begin
            b   = 8'($urandom());
            sum = sum + b;
            s.push_back(b);
         end
         s.push_back(($urandom_range(0, 1) == 1) ? sum : sum + 8'd1);
         run_stream("random", s, 1'b1);
      end

      // Full 2**AW-word image: last write at the top address, then the address wraps.
      s = {MG, 8'h00, 8'h04};
      sum = 8'h00;
      repeat (4 * (1 << AW)) begin
         b   = 8'($urandom());
         sum = sum + b;
         s.push_back(b);
      end
      s.push_back(sum);
      run_stream("full_image", s, 1'b0);
      check("full_image_addr_wrap", {{(32-AW){1'b0}}, imem_addr}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
